// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared constants for the instruction fetch path.
//   NOP_INSTR        : canonical RV32I NOP (addi x0, x0, 0), used as the bubble
//   DEFAULT_RESET_PC : PC loaded on reset unless the instance overrides it
//   INSTR_BYTES      : byte stride between sequential instruction words
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

endpackage : riscv_pkg

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program counter register with next-PC priority: rst > redirect > stall >
// sequential (+4, wrapping modulo 2^ADDRESS_WIDTH). The PC is always
// word-aligned: the low two bits of the reset value and of redirect targets
// are cleared before they are loaded.
// Ports:
//   clk             : rising-edge clock
//   rst             : synchronous active-high reset
//   stall           : hold the current PC
//   redirect        : load PC from redirect_target (wins over stall)
//   redirect_target : branch/jump byte address
//   pc              : current fetch byte address (registered)
// -----------------------------------------------------------------------------
module pc_reg
    import riscv_pkg::*;
#(
    parameter int unsigned                ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    output logic [ADDRESS_WIDTH-1:0] pc
);

    // Clearing the two low bits keeps every fetch address word-aligned.
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK       = ~ADDRESS_WIDTH'(32'd3);
    localparam logic [ADDRESS_WIDTH-1:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;
    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP          = ADDRESS_WIDTH'(INSTR_BYTES);

    logic [ADDRESS_WIDTH-1:0] pc_r;
    logic [ADDRESS_WIDTH-1:0] pc_next_s;

    // Next-PC selection; reset is applied in the register process.
    always_comb begin
        pc_next_s = pc_r;
        if (redirect) begin
            pc_next_s = redirect_target & ALIGN_MASK;
        end else if (stall) begin
            pc_next_s = pc_r;
        end else begin
            // Natural overflow of the adder gives the required wrap to zero.
            pc_next_s = pc_r + PC_STEP;
        end
    end

    // PC state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC_ALIGNED;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    assign pc = pc_r;

endmodule : pc_reg

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: drives the PC to instruction memory and captures
// the returned word plus its PC into the IF/ID pipeline register.
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   stall_i           : hold PC and IF/ID (hazard stall)
//   flush_i           : load a bubble into IF/ID
//   redirect_i        : take branch/jump to redirect_target_i; squashes IF/ID
//   redirect_target_i : branch/jump target byte address
//   instruction_i     : combinational memory word for pc_o
//   pc_o              : current fetch address
//   if_id_instr_o     : latched instruction
//   if_id_pc_o        : PC of latched instruction
//   if_id_pc4_o       : if_id_pc_o + 4 (0 for a bubble)
//   if_id_valid_o     : latched instruction is real, not a bubble
//   fetch_count_o     : number of valid instructions latched (wraps at 2^32)
// -----------------------------------------------------------------------------
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned                DATA_WIDTH    = 32,
    parameter int unsigned                ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic                     redirect_i,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target_i,
    input  logic [DATA_WIDTH-1:0]    instruction_i,
    output logic [ADDRESS_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0]    if_id_instr_o,
    output logic [ADDRESS_WIDTH-1:0] if_id_pc_o,
    output logic [ADDRESS_WIDTH-1:0] if_id_pc4_o,
    output logic                     if_id_valid_o,
    output logic [31:0]              fetch_count_o
);

    localparam logic [DATA_WIDTH-1:0]    BUBBLE_INSTR = DATA_WIDTH'(NOP_INSTR);
    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP      = ADDRESS_WIDTH'(INSTR_BYTES);

    logic [ADDRESS_WIDTH-1:0] pc_s;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_s;

    logic [DATA_WIDTH-1:0]    if_id_instr_r;
    logic [ADDRESS_WIDTH-1:0] if_id_pc_r;
    logic [ADDRESS_WIDTH-1:0] if_id_pc4_r;
    logic                     if_id_valid_r;
    logic [31:0]              fetch_count_r;

    pc_reg #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .RESET_PC      (RESET_PC)
    ) u_pc_reg (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall_i),
        .redirect        (redirect_i),
        .redirect_target (redirect_target_i),
        .pc              (pc_s)
    );

    assign pc_plus4_s = pc_s + PC_STEP;

    // IF/ID register and valid-fetch counter. Redirect or flush squash the
    // word on the wrong path even while stalled; a plain stall holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_instr_r <= BUBBLE_INSTR;
            if_id_pc_r    <= '0;
            if_id_pc4_r   <= '0;
            if_id_valid_r <= 1'b0;
            fetch_count_r <= 32'd0;
        end else if (redirect_i || flush_i) begin
            if_id_instr_r <= BUBBLE_INSTR;
            if_id_pc_r    <= '0;
            if_id_pc4_r   <= '0;
            if_id_valid_r <= 1'b0;
            fetch_count_r <= fetch_count_r;
        end else if (stall_i) begin
            if_id_instr_r <= if_id_instr_r;
            if_id_pc_r    <= if_id_pc_r;
            if_id_pc4_r   <= if_id_pc4_r;
            if_id_valid_r <= if_id_valid_r;
            fetch_count_r <= fetch_count_r;
        end else begin
            if_id_instr_r <= instruction_i;
            if_id_pc_r    <= pc_s;
            if_id_pc4_r   <= pc_plus4_s;
            if_id_valid_r <= 1'b1;
            fetch_count_r <= fetch_count_r + 32'd1;
        end
    end

    assign pc_o          = pc_s;
    assign if_id_instr_o = if_id_instr_r;
    assign if_id_pc_o    = if_id_pc_r;
    assign if_id_pc4_o   = if_id_pc4_r;
    assign if_id_valid_o = if_id_valid_r;
    assign fetch_count_o = fetch_count_r;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. Instruction memory returns word = address.
// A behavioural model tracks the expected PC / IF/ID / counter and is compared
// every cycle; directed scenarios add hand-computed literal expectations.
// A second instance with RESET_PC = 32'hFFFF_FFF8 exercises the PC wrap.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT signals
    logic        rst, stall, flush, redirect;
    logic [31:0] tgt;
    logic [31:0] instruction;
    logic [31:0] pc, id_instr, id_pc, id_pc4, count;
    logic        id_valid;

    // Wrap-test DUT signals
    logic        rst2;
    logic        zero_bit = 1'b0;
    logic [31:0] zero_word = 32'd0;
    logic [31:0] instruction2;
    logic [31:0] pc2, id_instr2, id_pc2, id_pc42, count2;
    logic        id_valid2;

    assign instruction  = pc;    // memory: word = address
    assign instruction2 = pc2;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
        .redirect_i(redirect), .redirect_target_i(tgt),
        .instruction_i(instruction), .pc_o(pc),
        .if_id_instr_o(id_instr), .if_id_pc_o(id_pc), .if_id_pc4_o(id_pc4),
        .if_id_valid_o(id_valid), .fetch_count_o(count)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst2), .stall_i(zero_bit), .flush_i(zero_bit),
        .redirect_i(zero_bit), .redirect_target_i(zero_word),
        .instruction_i(instruction2), .pc_o(pc2),
        .if_id_instr_o(id_instr2), .if_id_pc_o(id_pc2), .if_id_pc4_o(id_pc42),
        .if_id_valid_o(id_valid2), .fetch_count_o(count2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Architectural view: a fetch pointer, the last decoded slot, and a count.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return a;
    endfunction

    logic        m_known = 1'b0;
    logic [31:0] m_pc, m_instr, m_id_pc, m_id_pc4, m_count;
    logic        m_valid;

    always @(posedge clk) begin
        if (rst) begin
            m_known  <= 1'b1;
            m_pc     <= 32'd0;
            m_instr  <= NOP;
            m_id_pc  <= 32'd0;
            m_id_pc4 <= 32'd0;
            m_valid  <= 1'b0;
            m_count  <= 32'd0;
        end else begin
            // Fetch pointer: jump target (word-aligned), else advance unless stalled.
            m_pc <= redirect ? (tgt / 32'd4) * 32'd4
                             : m_pc + (stall ? 32'd0 : 32'd4);
            if (redirect || flush) begin
                m_instr  <= NOP;
                m_id_pc  <= 32'd0;
                m_id_pc4 <= 32'd0;
                m_valid  <= 1'b0;
            end else if (!stall) begin
                m_instr  <= imem(m_pc);
                m_id_pc  <= m_pc;
                m_id_pc4 <= m_pc + 32'd4;
                m_valid  <= 1'b1;
                m_count  <= m_count + 32'd1;
            end
        end
    end

    // Single compare process against the model.
    always @(negedge clk) begin
        if (m_known) begin
            chk("model_pc",       pc,                m_pc);
            chk("model_instr",    id_instr,          m_instr);
            chk("model_id_pc",    id_pc,             m_id_pc);
            chk("model_id_pc4",   id_pc4,            m_id_pc4);
            chk("model_valid",    {31'd0, id_valid}, {31'd0, m_valid});
            chk("model_count",    count,             m_count);
        end
    end

    // Apply inputs just after a falling edge and advance to the next falling edge.
    task automatic drive(input logic r, input logic s, input logic f,
                         input logic d, input logic [31:0] t);
        rst = r; stall = s; flush = f; redirect = d; tgt = t;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; tgt = 32'd0;
        rst2 = 1'b1;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

        // Reset state
        chk("rst_pc",    pc,                32'h0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_instr", id_instr,          NOP);
        chk("rst_count", count,             32'd0);

        // Four free cycles from reset
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
            chk("free_pc",    pc,    32'(4 * (k + 1)));
            chk("free_id_pc", id_pc, 32'(4 * k));
        end
        chk("free_count", count,  32'd4);
        chk("free_instr", id_instr, 32'd12);
        chk("free_pc4",   id_pc4, 32'd16);

        // Reset, run to pc=8, stall two cycles
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("pre_stall_pc", pc, 32'd8);
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
            chk("stall_pc",    pc,    32'd8);
            chk("stall_id_pc", id_pc, 32'd4);
            chk("stall_count", count, 32'd2);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("resume_pc",    pc,    32'd12);
        chk("resume_id_pc", id_pc, 32'd8);
        chk("resume_count", count, 32'd3);

        // Redirect at pc=12 to 0x42
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0042);
        chk("redir_pc",    pc,                32'h40);
        chk("redir_valid", {31'd0, id_valid}, 32'd0);
        chk("redir_instr", id_instr,          NOP);
        chk("redir_count", count,             32'd3);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("post_redir_pc",    pc,       32'h44);
        chk("post_redir_instr", id_instr, 32'h40);
        chk("post_redir_pc4",   id_pc4,   32'h44);

        // Redirect + stall + flush together
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
        chk("all3_pc",    pc,                32'h100);
        chk("all3_valid", {31'd0, id_valid}, 32'd0);
        chk("all3_id_pc", id_pc,             32'd0);

        // Flush alone: PC advances, bubble
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        chk("flush_pc",    pc,                32'h108);
        chk("flush_valid", {31'd0, id_valid}, 32'd0);
        // Stall + flush: PC holds, bubble
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        chk("stflush_pc",    pc,                32'h10C);
        chk("stflush_valid", {31'd0, id_valid}, 32'd0);
        chk("stflush_count", count,             32'd6);

        // Reset during stall at pc=20
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("pre_rst_pc", pc, 32'd20);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("rst_stall_pc",    pc,                32'd0);
        chk("rst_stall_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_stall_count", count,             32'd0);
        // Reset overrides redirect
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0080);
        chk("rst_redir_pc", pc, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("first_fetch_id_pc", id_pc, 32'd0);
        chk("first_fetch_pc",    pc,    32'd4);

        // Wrap test on second instance
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("wrap_rst_pc", pc2, 32'hFFFF_FFF8);
        rst2 = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("wrap_pc1", pc2, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("wrap_pc2",     pc2,    32'h0000_0000);
        chk("wrap_id_pc",   id_pc2, 32'hFFFF_FFFC);
        chk("wrap_id_pc4",  id_pc42, 32'h0000_0000);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("wrap_pc3",   pc2,    32'h0000_0004);
        chk("wrap_count", count2, 32'd3);
        chk("wrap_instr", id_instr2, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_unit
